gate_response_checker: RTL
==========================

// Module: gate_response_checker
// PURPOSE
//   Self-checking monitor for 2-input logic-gate DUTs: the receiving end of the gate stimulus sequence.
//   Samples (A,B,Y) on a valid strobe and compares Y against the selected gate function.
//   Counts mismatches and tracks truth-table coverage, then reports done/pass.
//   Sits beside the gate DUT in the bench or on-chip BIST; the stimulus source drives A/B and smp_valid.
// PARAMETERS
//   ERR_W       8    width of error counter; saturates at 2**ERR_W-1
//   CNT_W       8    width of sample counter
//   MAX_SAMPLES 64   samples accepted before forced completion (timeout); must be >= 4 and < 2**CNT_W
// PORTS
//   clk        in   1      clock; all logic on rising edge
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      1-cycle pulse: clear results, latch gate_sel, begin run
//   gate_sel   in   3      0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6/7 illegal
//   smp_valid  in   1      sample strobe; A/B/Y valid this cycle
//   smp_a      in   1      DUT input A
//   smp_b      in   1      DUT input B
//   smp_y      in   1      DUT output Y
//   busy       out  1      high in RUN
//   done       out  1      high in DONE; held until next start or reset
//   pass       out  1      valid when done: err_cnt==0 and cov_map==4'hF
//   err_cnt    out  ERR_W  mismatch count, saturating
//   smp_cnt    out  CNT_W  samples accepted this run
//   cov_map    out  4      bit {a,b} set when that combination was sampled
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state IDLE; busy=0, done=0, pass=0, err_cnt=0, smp_cnt=0, cov_map=0.
//   - FSM states IDLE, RUN, DONE.
//     IDLE -start-> RUN; DONE -start-> RUN; start in RUN ignored.
//     On start: clear err_cnt/smp_cnt/cov_map/pass, latch gate_sel.
//     smp_valid in the same cycle as start is ignored.
//   - Illegal gate_sel (6/7) at start: go directly to DONE with pass=0, err_cnt=0.
//   - RUN, smp_valid=1: exp = f(gate_sel,a,b); if smp_y!=exp then err_cnt+1 (saturates at max);
//     smp_cnt+1; cov_map[{a,b}] set. All outputs registered; visible the cycle after the sample.
//   - smp_valid ignored in IDLE and DONE; X/Z on smp_* while smp_valid=0 has no effect.
//   - Completion: a sample that completes cov_map=4'hF, or brings smp_cnt to MAX_SAMPLES,
//     moves the FSM to DONE on that same edge. done=1 and pass are valid the next cycle.
//     If both conditions occur on the same sample, result is identical (single transition).
//   - pass = (err_cnt_next==0) && (cov_map_next==4'hF); timeout without full coverage gives pass=0.
//   - Repeated combinations are counted and checked but do not advance coverage.
//   - Reset during RUN aborts the run: all outputs return to reset values; no partial result retained.
// CONFIGURATION
//   GRC_ERR_CAPTURE_EN defined: adds outputs
//     fe_valid 1, fe_idx CNT_W, fe_abY 3.
//     These capture smp_cnt index and {a,b,y} of the first mismatch in a run.
//     Cleared on start/reset; not overwritten by later mismatches.
//   GRC_ERR_CAPTURE_EN undefined: these ports and registers do not exist; all other behaviour identical.
// TESTING
//   1. gate_sel=0 (AND), samples ab=00,10,01,11 with y=0,0,0,1 -> done 1 cycle after 4th; pass=1, err_cnt=0, smp_cnt=4, cov_map=F.
//   2. AND, samples 00/y=0, 10/y=1, 01/y=0, 11/y=1 -> pass=0, err_cnt=1.
//      With GRC_ERR_CAPTURE_EN: fe_idx=1, fe_abY=3'b101.
//   3. XOR, only ab=00 with correct y repeated 64 times -> timeout DONE; smp_cnt=64, cov_map=1, pass=0.
//   4. ERR_W=2, NAND, 5 wrong samples before coverage completes -> err_cnt saturates at 3; pass=0.
//   5. Reset mid-run after 2 samples -> all outputs 0. start, full correct OR sequence -> pass=1.
//   6. gate_sel=7 + start -> DONE next cycle, pass=0. Then start during RUN mid-sequence -> ignored; counts continue.

Source files
------------

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_response_checker
// Purpose  : Response monitor for 2-input logic-gate DUTs. Samples (a,b,y)
//            on a valid strobe and compares y against the gate function
//            latched at start. It counts mismatches with saturation, tracks
//            truth-table coverage and then reports done/pass.
// Ports    : clk, rst_n (sync, active low), start, gate_sel[2:0],
//            smp_valid, smp_a, smp_b, smp_y            -> inputs
//            busy, done, pass, err_cnt[ERR_W-1:0],
//            smp_cnt[CNT_W-1:0], cov_map[3:0]          -> outputs
//            fe_valid, fe_idx[CNT_W-1:0], fe_abY[2:0]  -> outputs, present
//            only when GRC_ERR_CAPTURE_EN is defined (first-mismatch capture)
// Config   : GRC_ERR_CAPTURE_EN (macro) enables the first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
  parameter int ERR_W       = 8,
  parameter int CNT_W       = 8,
  parameter int MAX_SAMPLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [3:0]       cov_map
`ifdef GRC_ERR_CAPTURE_EN
  ,
  output logic             fe_valid,
  output logic [CNT_W-1:0] fe_idx,
  output logic [2:0]       fe_abY
`endif
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [ERR_W-1:0] c_err_max = {ERR_W{1'b1}};
  localparam logic [CNT_W-1:0] c_max_smp = CNT_W'(MAX_SAMPLES);

  logic [1:0]       r_state;
  logic [2:0]       r_sel;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cov;

  logic             w_exp;
  logic             w_mis;
  logic [ERR_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_cov_nxt;
  logic             w_fin;

  // Expected gate output for the latched function. The smp_* inputs may be
  // X while smp_valid is low; these terms are only consumed under smp_valid.
  always_comb begin
    w_exp = 1'b0;
    case (r_sel)
      3'd0:    w_exp =   smp_a & smp_b;
      3'd1:    w_exp =   smp_a | smp_b;
      3'd2:    w_exp = ~(smp_a & smp_b);
      3'd3:    w_exp = ~(smp_a | smp_b);
      3'd4:    w_exp =   smp_a ^ smp_b;
      3'd5:    w_exp = ~(smp_a ^ smp_b);
      default: w_exp = 1'b0;
    endcase
  end

  always_comb begin
    w_mis     = (smp_y != w_exp);
    w_err_nxt = (w_mis && (r_err != c_err_max)) ? r_err + 1'b1 : r_err;
    w_cnt_nxt = r_cnt + 1'b1;
    w_cov_nxt = r_cov | (4'b0001 << {smp_a, smp_b});
    // Full coverage and the sample limit may coincide; either ends the run.
    w_fin     = (w_cov_nxt == 4'hF) || (w_cnt_nxt == c_max_smp);
  end

`ifdef GRC_ERR_CAPTURE_EN
  logic             r_fe_valid;
  logic [CNT_W-1:0] r_fe_idx;
  logic [2:0]       r_fe_aby;

  // Only the first mismatch of a run is kept; later ones leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fe_valid <= 1'b0;
      r_fe_idx   <= '0;
      r_fe_aby   <= '0;
    end else if (start && (r_state != c_st_run)) begin
      r_fe_valid <= 1'b0;
      r_fe_idx   <= '0;
      r_fe_aby   <= '0;
    end else if ((r_state == c_st_run) && smp_valid && w_mis && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_idx   <= r_cnt;
      r_fe_aby   <= {smp_a, smp_b, smp_y};
    end
  end

  assign fe_valid = r_fe_valid;
  assign fe_idx   = r_fe_idx;
  assign fe_abY   = r_fe_aby;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_sel   <= 3'd0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_cov   <= 4'h0;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (start) begin
            r_sel  <= gate_sel;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_cnt  <= '0;
            r_cov  <= 4'h0;
            // Illegal selections finish immediately with a failing result.
            r_state <= (gate_sel <= 3'd5) ? c_st_run : c_st_done;
          end
        end
        c_st_run: begin
          if (smp_valid) begin
            r_err <= w_err_nxt;
            r_cnt <= w_cnt_nxt;
            r_cov <= w_cov_nxt;
            if (w_fin) begin
              r_state <= c_st_done;
              r_pass  <= (w_err_nxt == '0) && (w_cov_nxt == 4'hF);
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign busy    = (r_state == c_st_run);
  assign done    = (r_state == c_st_done);
  assign pass    = r_pass;
  assign err_cnt = r_err;
  assign smp_cnt = r_cnt;
  assign cov_map = r_cov;

endmodule
`default_nettype wire
